// File: rtl/lane_spawner.sv
// lane_spawner: walks a set of lanes one at a time. For each lane it loads a
// pseudo-random car configuration, lets it settle for one cycle, then raises
// that lane's one-hot spawn strobe for HOLD cycles. A 16-bit Galois LFSR
// free-runs in every state and supplies the random configuration bits.
module lane_spawner #(
   parameter int          LANES = 8,
   parameter int          HOLD  = 4,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             Clk,
   input  logic             ResetN,
   input  logic             Start,
   input  logic [2:0]       Level,
   output logic [LANES-1:0] SpawnEnable,
   output logic             Direction,
   output logic [1:0]       CarType,
   output logic [2:0]       CarCount,
   output logic [2:0]       CarSpeed,
   output logic             Busy,
   output logic             Done
);

   // A one-lane build still needs a one-bit index register.
   localparam int          IW        = (LANES > 1) ? $clog2(LANES) : 1;
   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [IW-1:0] LAST_LANE = IW'(LANES - 1);
   localparam logic [3:0]  HOLD_LAST = 4'(HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_PULSE,
      S_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [IW-1:0]    index_reg, index_next;
   logic [3:0]       hold_reg, hold_next;
   logic [15:0]      lfsr_reg, lfsr_next;
   // Only Level[2:1] feeds the configuration arithmetic.
   logic [1:0]       level_reg;
   logic             level_unused;

   logic [LANES-1:0] spawn_next;
   logic             busy_next;
   logic             done_next;

   assign level_unused = Level[0];

   // Galois LFSR step: shift right, fold in the taps when a 1 falls out.
   always_comb begin
      lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
   end

   // State, lane index, hold counter, LFSR and captured level registers.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_reg <= S_IDLE;
         index_reg <= '0;
         hold_reg  <= '0;
         lfsr_reg  <= SEED_EFF;
         level_reg <= '0;
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
         hold_reg  <= hold_next;
         lfsr_reg  <= lfsr_next;
         if (state_reg == S_IDLE && Start) begin
            level_reg <= Level[2:1];
         end
      end
   end

   // Next-state logic: sequence LOAD -> SETTLE -> PULSE for each lane.
   always_comb begin
      state_next = state_reg;
      index_next = index_reg;
      hold_next  = hold_reg;
      case (state_reg)
         S_IDLE: begin
            if (Start) begin
               state_next = S_LOAD;
               index_next = '0;
            end
         end
         S_LOAD: begin
            state_next = S_SETTLE;
         end
         S_SETTLE: begin
            state_next = S_PULSE;
            hold_next  = '0;
         end
         S_PULSE: begin
            if (hold_reg == HOLD_LAST) begin
               if (index_reg == LAST_LANE) begin
                  state_next = S_DONE;
               end else begin
                  state_next = S_LOAD;
                  index_next = index_reg + IW'(1);
               end
            end else begin
               hold_next = hold_reg + 4'd1;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so every output is a flop.
   always_comb begin
      busy_next = (state_next == S_LOAD) || (state_next == S_SETTLE) ||
                  (state_next == S_PULSE);
      done_next = (state_next == S_DONE);
   end

   // One strobe bit per lane, high only while that lane is pulsing.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign spawn_next[gi] = (state_next == S_PULSE) && (index_next == IW'(gi));
      end
   endgenerate

   // Registered strobe and status outputs.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         SpawnEnable <= '0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
      end else begin
         SpawnEnable <= spawn_next;
         Busy        <= busy_next;
         Done        <= done_next;
      end
   end

   // Shared configuration changes only on the edge leaving LOAD, using the
   // LFSR value before that edge's advance; sums stay within 3 bits.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         Direction <= 1'b0;
         CarType   <= 2'd0;
         CarCount  <= 3'd0;
         CarSpeed  <= 3'd0;
      end else if (state_reg == S_LOAD) begin
         Direction <= lfsr_reg[0];
         CarType   <= lfsr_reg[2:1];
         CarCount  <= 3'd1 + {1'b0, lfsr_reg[4:3]} + {2'b00, level_reg[1]};
         CarSpeed  <= 3'd1 + {1'b0, lfsr_reg[7:6]} + {1'b0, level_reg};
      end
   end

endmodule
